// File: rtl/fft_band_pwm_meter.sv
// FFT spectrum meter: bins a one-sided magnitude stream into equal-width bands,
// holds a decaying per-band peak, and PWM-dims one LED per band.
module fft_band_pwm_meter #(
  parameter int unsigned NFFT     = 1024,
  parameter int unsigned DATA_W   = 65,
  parameter int unsigned N_BANDS  = 16,
  parameter int unsigned PWM_W    = 13,
  parameter int unsigned SHIFT    = 32,
  parameter int unsigned DECAY_SH = 3,
  parameter int unsigned DET_BAND = 15
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    fft_valid,
  output logic                    fft_ready,
  input  logic [$clog2(NFFT)-1:0] fft_index,
  input  logic [DATA_W-1:0]       fft_data,
  input  logic                    peak_mode,
  input  logic [PWM_W-1:0]        det_threshold,
  output logic [N_BANDS-1:0]      led,
  output logic                    detect,
  output logic                    frame_done
);

  localparam int unsigned IDX_W  = $clog2(NFFT);
  localparam int unsigned HALF   = NFFT / 2;
  localparam int unsigned BPB    = NFFT / (2 * N_BANDS);
  localparam int unsigned SUM_W  = DATA_W + $clog2(BPB);
  localparam int unsigned BAND_W = $clog2(N_BANDS);
  localparam logic [PWM_W-1:0] PWM_MAX = {PWM_W{1'b1}};

  logic [SUM_W-1:0] acc    [N_BANDS];
  logic [SUM_W-1:0] band   [N_BANDS];
  logic [SUM_W-1:0] peak   [N_BANDS];
  logic [PWM_W-1:0] bright [N_BANDS];
  logic [PWM_W-1:0] pwm_cnt;
  logic             armed;

  logic [SUM_W-1:0] peak_dec_c   [N_BANDS];
  logic [SUM_W-1:0] peak_nxt_c   [N_BANDS];
  logic [SUM_W-1:0] sel_c        [N_BANDS];
  logic [SUM_W-1:0] sel_sh_c     [N_BANDS];
  logic [PWM_W-1:0] bright_nxt_c [N_BANDS];

  logic              accept_c;
  logic              in_half_c;
  logic              latch_c;
  logic              off_zero_c;
  logic [BAND_W-1:0] band_c;

  assign fft_ready  = ~reset;
  assign accept_c   = fft_valid & fft_ready;
  assign in_half_c  = fft_index < IDX_W'(HALF);
  assign latch_c    = accept_c && (fft_index == IDX_W'(HALF));
  assign band_c     = BAND_W'(fft_index / IDX_W'(BPB));
  assign off_zero_c = (fft_index % IDX_W'(BPB)) == '0;

  // Accumulation only resumes at a band boundary after reset (armed).
  always_ff @(posedge clk) begin
    if (reset) begin
      armed <= 1'b0;
      for (int k = 0; k < int'(N_BANDS); k++) acc[k] <= '0;
    end else if (accept_c && in_half_c && (off_zero_c || armed)) begin
      armed <= 1'b1;
      if (off_zero_c) acc[band_c] <= SUM_W'(fft_data);
      else            acc[band_c] <= acc[band_c] + SUM_W'(fft_data);
    end
  end

  always_comb begin
    for (int k = 0; k < int'(N_BANDS); k++) begin
      peak_dec_c[k]   = peak[k] - (peak[k] >> DECAY_SH);
      peak_nxt_c[k]   = (acc[k] > peak_dec_c[k]) ? acc[k] : peak_dec_c[k];
      sel_c[k]        = peak_mode ? peak[k] : band[k];
      sel_sh_c[k]     = sel_c[k] >> SHIFT;
      bright_nxt_c[k] = (sel_sh_c[k] > SUM_W'(PWM_MAX)) ? PWM_MAX : sel_sh_c[k][PWM_W-1:0];
    end
  end

  // Frame latch: band/peak snapshot and frame_done on the cycle after the latch beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_done <= 1'b0;
      for (int k = 0; k < int'(N_BANDS); k++) begin
        band[k] <= '0;
        peak[k] <= '0;
      end
    end else begin
      frame_done <= latch_c;
      if (latch_c) begin
        for (int k = 0; k < int'(N_BANDS); k++) begin
          band[k] <= acc[k];
          peak[k] <= peak_nxt_c[k];
        end
      end
    end
  end

  // Brightness follows one cycle behind the snapshot, sampling peak_mode then.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < int'(N_BANDS); k++) bright[k] <= '0;
    end else if (frame_done) begin
      for (int k = 0; k < int'(N_BANDS); k++) bright[k] <= bright_nxt_c[k];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_cnt <= '0;
      led     <= '0;
      detect  <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_W'(1);
      for (int k = 0; k < int'(N_BANDS); k++) led[k] <= bright[k] > pwm_cnt;
      detect  <= bright[DET_BAND] > det_threshold;
    end
  end

endmodule

// File: tb/tb_fft_band_pwm_meter.sv
// Bench for fft_band_pwm_meter: drives frames, predicts band sums, peaks and
// brightness from the stream rules, and measures LED duty over a PWM period.
module tb_fft_band_pwm_meter;

  localparam int unsigned NFFT     = 1024;
  localparam int unsigned DATA_W   = 65;
  localparam int unsigned N_BANDS  = 16;
  localparam int unsigned PWM_W    = 13;
  localparam int unsigned SHIFT    = 32;
  localparam int unsigned DECAY_SH = 3;
  localparam int unsigned DET_BAND = 15;
  localparam int unsigned IDX_W    = 10;
  localparam int unsigned HALF     = 512;
  localparam int unsigned BPB      = 32;
  localparam int unsigned SUM_W    = 70;
  localparam int          PERIOD   = 8192;
  localparam int          BMAX     = 8191;

  logic                 clk;
  logic                 reset;
  logic                 fft_valid;
  logic                 fft_ready;
  logic [IDX_W-1:0]     fft_index;
  logic [DATA_W-1:0]    fft_data;
  logic                 peak_mode;
  logic [PWM_W-1:0]     det_threshold;
  logic [N_BANDS-1:0]   led;
  logic                 detect;
  logic                 frame_done;

  fft_band_pwm_meter #(
    .NFFT(NFFT), .DATA_W(DATA_W), .N_BANDS(N_BANDS), .PWM_W(PWM_W),
    .SHIFT(SHIFT), .DECAY_SH(DECAY_SH), .DET_BAND(DET_BAND)
  ) dut (
    .clk(clk), .reset(reset), .fft_valid(fft_valid), .fft_ready(fft_ready),
    .fft_index(fft_index), .fft_data(fft_data), .peak_mode(peak_mode),
    .det_threshold(det_threshold), .led(led), .detect(detect), .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int fd_count = 0;

  logic [DATA_W-1:0] frame_data [HALF];
  logic [SUM_W-1:0]  exp_band   [N_BANDS];
  logic [SUM_W-1:0]  exp_peak   [N_BANDS];
  int                exp_bright [N_BANDS];

  always @(negedge clk) if (frame_done === 1'b1) fd_count++;

  task automatic model_reset();
    for (int k = 0; k < int'(N_BANDS); k++) begin
      exp_band[k] = '0;
      exp_peak[k] = '0;
      exp_bright[k] = 0;
    end
  endtask

  // Bands first_b..last_b were sent complete this frame; others keep their old sums.
  task automatic model_latch(input int first_b, input int last_b);
    logic [SUM_W-1:0] sum, dec, sel, sh;
    for (int b = first_b; b <= last_b; b++) begin
      sum = '0;
      for (int o = 0; o < int'(BPB); o++) sum = sum + SUM_W'(frame_data[b*int'(BPB) + o]);
      exp_band[b] = sum;
    end
    for (int k = 0; k < int'(N_BANDS); k++) begin
      dec = exp_peak[k] - (exp_peak[k] >> DECAY_SH);
      exp_peak[k] = (exp_band[k] > dec) ? exp_band[k] : dec;
      sel = peak_mode ? exp_peak[k] : exp_band[k];
      sh = sel >> SHIFT;
      exp_bright[k] = (sh > SUM_W'(BMAX)) ? BMAX : int'(sh[PWM_W-1:0]);
    end
  endtask

  task automatic check_idle(input string name);
    checks++;
    if (led !== '0 || detect !== 1'b0 || frame_done !== 1'b0 || fft_ready !== 1'b0) begin
      failures++;
      $display("FAIL %s: led=%h detect=%b frame_done=%b fft_ready=%b, expected all 0",
               name, led, detect, frame_done, fft_ready);
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    fft_valid = 1'b0;
    reset = 1'b1;
    repeat (n) begin
      @(negedge clk);
      check_idle("reset_outputs");
    end
    reset = 1'b0;
    model_reset();
  endtask

  task automatic beat(input int idx, input logic [DATA_W-1:0] d);
    @(negedge clk);
    fft_valid = 1'b1;
    fft_index = IDX_W'(idx);
    fft_data  = d;
  endtask

  task automatic send_bins(input int first, input int last, input bit gaps);
    for (int i = first; i <= last; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 5)) begin
          @(negedge clk);
          fft_valid = 1'b0;
          fft_index = IDX_W'($urandom);
        end
      end
      beat(i, frame_data[i]);
    end
  endtask

  task automatic send_latch();
    beat(HALF, {1'b1, $urandom, $urandom});
    @(negedge clk);
    fft_valid = 1'b0;
  endtask

  task automatic check_frame(input string name, input int fd_before, output int led0_cnt);
    int cnt [N_BANDS];
    logic exp_det;
    repeat (3) @(negedge clk);
    checks++;
    if (fd_count - fd_before !== 1) begin
      failures++;
      $display("FAIL %s frame_done: got %0d high cycles, expected 1", name, fd_count - fd_before);
    end
    for (int k = 0; k < int'(N_BANDS); k++) cnt[k] = 0;
    repeat (PERIOD) begin
      @(negedge clk);
      for (int k = 0; k < int'(N_BANDS); k++) if (led[k] === 1'b1) cnt[k]++;
    end
    for (int k = 0; k < int'(N_BANDS); k++) begin
      checks++;
      if (cnt[k] !== exp_bright[k]) begin
        failures++;
        $display("FAIL %s led[%0d] duty: got %0d, expected %0d", name, k, cnt[k], exp_bright[k]);
      end
    end
    exp_det = exp_bright[DET_BAND] > int'(det_threshold);
    checks++;
    if (detect !== exp_det) begin
      failures++;
      $display("FAIL %s detect: got %b, expected %b", name, detect, exp_det);
    end
    led0_cnt = cnt[0];
  endtask

  task automatic test_reset();
    int fd0, c0;
    reset = 1'b1;
    fft_valid = 1'b0;
    fft_index = '0;
    fft_data = '0;
    peak_mode = 1'b0;
    det_threshold = PWM_W'(20);
    repeat (3) begin
      @(negedge clk);
      check_idle("initial_reset");
    end
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < int'(HALF); i++) frame_data[i] = DATA_W'(64'd1 << 32);
    fd0 = fd_count;
    send_bins(0, 99, 1'b0);
    @(negedge clk);
    fft_index = IDX_W'(100);
    fft_data = frame_data[100];
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_idle("midframe_reset");
    end
    reset = 1'b0;
    model_reset();
    #1;
    checks++;
    if (fft_ready !== 1'b1) begin
      failures++;
      $display("FAIL ready_after_reset: got %b, expected 1", fft_ready);
    end
    send_bins(101, 511, 1'b0);
    send_latch();
    model_latch(4, 15);
    check_frame("reset_frame", fd0 + 0, c0);
  endtask

  task automatic test_uniform();
    int fd0, c0;
    det_threshold = PWM_W'(31);
    for (int i = 0; i < int'(HALF); i++) frame_data[i] = DATA_W'(64'd1 << 32);
    fd0 = fd_count;
    send_bins(0, 511, 1'b0);
    send_latch();
    model_latch(0, 15);
    check_frame("uniform", fd0, c0);
  endtask

  task automatic test_gaps();
    int fd0, c0, w;
    logic [DATA_W-1:0] m;
    det_threshold = PWM_W'($urandom_range(0, BMAX));
    for (int b = 0; b < int'(N_BANDS); b++) begin
      w = $urandom_range(28, 40);
      m = (DATA_W'(1) << w) - DATA_W'(1);
      for (int o = 0; o < int'(BPB); o++) frame_data[b*int'(BPB) + o] = {1'b0, $urandom, $urandom} & m;
    end
    fd0 = fd_count;
    send_bins(0, 511, 1'b1);
    repeat (3) beat($urandom_range(HALF + 1, NFFT - 1), {1'b1, $urandom, $urandom});
    send_latch();
    model_latch(0, 15);
    check_frame("gaps_random", fd0, c0);
  endtask

  task automatic test_saturation();
    int fd0, c0;
    det_threshold = PWM_W'(100);
    for (int i = 0; i < int'(HALF); i++) frame_data[i] = (i >= 480) ? DATA_W'(64'd1 << 40) : '0;
    fd0 = fd_count;
    send_bins(0, 511, 1'b0);
    send_latch();
    model_latch(0, 15);
    check_frame("saturation", fd0, c0);
    det_threshold = PWM_W'(BMAX);
    repeat (2) @(negedge clk);
    checks++;
    if (detect !== 1'b0) begin
      failures++;
      $display("FAIL detect_thr_max: got %b, expected 0", detect);
    end
    det_threshold = PWM_W'(BMAX - 1);
    repeat (2) @(negedge clk);
    checks++;
    if (detect !== 1'b1) begin
      failures++;
      $display("FAIL detect_thr_max_minus1: got %b, expected 1", detect);
    end
  endtask

  task automatic test_partial();
    int fd0, c0;
    for (int i = 0; i < int'(HALF); i++) frame_data[i] = DATA_W'(64'd1 << 33);
    fd0 = fd_count;
    send_bins(0, 31, 1'b0);
    send_latch();
    model_latch(0, 0);
    check_frame("partial", fd0, c0);
  endtask

  task automatic test_peak_decay();
    int fd0, c0;
    int spec_seq [4];
    spec_seq[0] = 800; spec_seq[1] = 700; spec_seq[2] = 612; spec_seq[3] = 535;
    do_reset(3);
    peak_mode = 1'b1;
    det_threshold = PWM_W'(0);
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < int'(HALF); i++)
        frame_data[i] = (f == 0 && i < int'(BPB)) ? DATA_W'(64'd25 << 32) : '0;
      fd0 = fd_count;
      send_bins(0, 511, 1'b0);
      send_latch();
      model_latch(0, 15);
      check_frame("peak_decay", fd0, c0);
      checks++;
      if (c0 !== spec_seq[f]) begin
        failures++;
        $display("FAIL peak_seq frame %0d: got %0d, expected %0d", f + 1, c0, spec_seq[f]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_uniform();
    test_gaps();
    test_saturation();
    test_partial();
    test_peak_decay();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fft_band_pwm_meter.md
Name: fft_band_pwm_meter

Overview:
- Parametrised FFT spectrum meter that bins a one-sided magnitude stream into N_BANDS equal-width bands, one PWM-dimmed LED per band.
- Adds per-band peak-hold with decay and a band-threshold detector output.
- Sits after the FFT magnitude stage. Single clock domain. Drives the board LED bank.

Parameters:
NFFT, 1024, FFT length; power of 2, ≥ 2*N_BANDS.
DATA_W, 65, width of fft_data (unsigned magnitude²).
N_BANDS, 16, number of bands/LEDs; power of 2.
PWM_W, 13, PWM counter and brightness width.
SHIFT, 32, right shift applied to the band value before brightness saturation.
DECAY_SH, 3, peak decay per frame: peak -= peak >> DECAY_SH.
DET_BAND, 15, band index monitored by the detector.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
fft_valid  in  1  stream sample valid
fft_ready  out  1  stream ready
fft_index  in  $clog2(NFFT)  bin index of the current sample
fft_data  in  DATA_W  bin magnitude (unsigned)
peak_mode  in  1  1 = display peak-hold value; 0 = display instantaneous band sum
det_threshold  in  PWM_W  detector threshold, compared with band DET_BAND brightness
led  out  N_BANDS  PWM LED outputs; bit k = band k
detect  out  1  high while brightness[DET_BAND] > det_threshold
frame_done  out  1  one-cycle pulse when a frame is latched

Behaviour:
Reset:
- reset high at a clock edge clears accumulators, band registers, peak registers, brightness registers and pwm_cnt.
- Outputs led=0, detect=0, frame_done=0.
- fft_ready=0 during reset, 1 otherwise.
- Reset mid-frame discards the partial frame. The next accumulation starts only at an index with bin offset 0.

Stream:
- A beat is accepted when fft_valid & fft_ready.
- Gaps (fft_valid=0) are allowed anywhere and hold all state.

Binning:
- BPB = NFFT/(2*N_BANDS). SUM_W = DATA_W + $clog2(BPB).
- For accepted beats with index < NFFT/2: band b = index / BPB, offset o = index % BPB.
- If o==0: acc[b] <= fft_data (zero-extended). Otherwise: acc[b] <= acc[b] + fft_data.
- The sum cannot overflow because SUM_W is sized for BPB full-scale samples.
- Beats with index ≥ NFFT/2 are accepted and ignored, except index == NFFT/2, which is the frame latch.

Frame latch (accepted beat with index == NFFT/2, cycle T):
- T+1: band[k] <= acc[k] for all k.
- T+1: peak[k] <= max(acc[k], peak[k] − (peak[k] >> DECAY_SH)).
- T+1: frame_done pulses high for exactly 1 cycle.
- T+2: brightness[k] <= min((sel[k] >> SHIFT), 2^PWM_W − 1), where sel = peak_mode ? peak : band.
- A frame with missing bins still latches; each band holds whatever its accumulator last held.
- The latch beat must not alter any accumulator.

PWM:
- pwm_cnt is a free-running PWM_W-bit counter; it wraps 2^PWM_W−1 → 0.
- led[k] is registered: led[k] <= (brightness[k] > pwm_cnt).
- brightness 0 → LED always off. brightness 2^PWM_W−1 → LED on for all counts except 2^PWM_W−1.
- Brightness updates take effect on the cycle after they are written. There is no PWM-period alignment and no glitch filtering.

Detector:
- Registered: detect <= brightness[DET_BAND] > det_threshold. This is a strict compare.
- Latency is 1 cycle after a brightness or det_threshold change.

peak_mode:
- Sampled only at brightness computation (T+2).
- Toggling peak_mode mid-frame takes effect on the next frame latch.

Simultaneous events:
- reset has priority over every other action.
- A latch beat concurrent with a PWM wrap needs no special handling.

Test Plan:
- Reset check: assert reset 3 cycles, mid-frame at index 100 → led=0, detect=0, frame_done=0, fft_ready=0 during reset. After release, bins 101..127 do not contribute to band 3 until index 128.
- Uniform frame: NFFT=1024, N_BANDS=16, fft_data=2^32 on every bin 0..511, then index 512 → frame_done pulses 1 cycle, band[k]=32·2^32, brightness[k]=32 for all k. Over 8192 cycles each led[k] is high exactly 32 cycles.
- Saturation and detector: bins 480..511 at fft_data=2^40, det_threshold=100 → brightness[15]=8191, led[15] high 8191 of 8192 cycles, detect=1. With det_threshold=8191 → detect=0.
- Peak decay: peak_mode=1, DECAY_SH=3. Frame 1: band 0 sum = 800·2^32. Frames 2–4: all-zero data → brightness[0] sequence 800, 700, 612, 535.
- Backpressure-free gaps: the same frame as the uniform case with fft_valid low for random 0–5 cycles between beats → identical band values and identical frame_done count.
- Partial frame: send only bins 0..31 then index 512, fft_data=2^33 → brightness[0]=64. Other bands retain their previous-frame sums.
